// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: zero-latency IF lookup,
// EX-stage mispredict detection and registered training. Optional stats: BP_STATS_EN.
module branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int CTR_BITS   = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
`ifdef BP_STATS_EN
  output logic [31:0]           stat_cf_count,
  output logic [31:0]           stat_mispredict_count,
`endif
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_next_pc,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pred_next_pc,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic                  tbl_valid  [ENTRIES];
  logic [TAG_W-1:0]      tbl_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] tbl_target [ENTRIES];
  logic [CTR_BITS-1:0]   tbl_ctr    [ENTRIES];

  logic [IDX_W-1:0]      if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  logic                  if_hit, ex_hit, ex_cf;
  logic [ADDR_WIDTH-1:0] ex_pc_plus4, actual_next;

  // Lookup sees pre-update table contents; no bypass from the EX write.
  assign if_idx       = if_pc[IDX_W+1:2];
  assign if_tag       = if_pc[ADDR_WIDTH-1:IDX_W+2];
  assign if_hit       = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
  assign pred_taken   = if_hit && tbl_ctr[if_idx][CTR_BITS-1];
  assign pred_next_pc = pred_taken ? tbl_target[if_idx] : if_pc + ADDR_WIDTH'(4);

  assign ex_idx      = ex_pc[IDX_W+1:2];
  assign ex_tag      = ex_pc[ADDR_WIDTH-1:IDX_W+2];
  assign ex_hit      = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
  assign ex_cf       = ex_is_branch || ex_is_jump;
  assign ex_pc_plus4 = ex_pc + ADDR_WIDTH'(4);
  assign actual_next = ex_taken ? ex_target : ex_pc_plus4;

  // A predicted-taken non-control-flow instruction is a stale or aliased hit.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (ex_valid) begin
      if (ex_cf) begin
        mispredict  = (actual_next != ex_pred_next_pc);
        redirect_pc = actual_next;
      end else begin
        mispredict  = ex_pred_taken;
        redirect_pc = ex_pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_ctr[i]   <= CTR_WNT;
      end
    end else if (ex_valid) begin
      if (ex_hit) begin
        if (ex_is_jump) begin
          tbl_ctr[ex_idx] <= CTR_MAX;
        end else if (ex_is_branch) begin
          if (ex_taken) begin
            if (tbl_ctr[ex_idx] != CTR_MAX) tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] + CTR_BITS'(1);
          end else begin
            if (tbl_ctr[ex_idx] != '0) tbl_ctr[ex_idx] <= tbl_ctr[ex_idx] - CTR_BITS'(1);
          end
        end else begin
          tbl_valid[ex_idx] <= 1'b0;
        end
      end else if (ex_cf && ex_taken) begin
        tbl_valid[ex_idx] <= 1'b1;
        tbl_ctr[ex_idx]   <= ex_is_jump ? CTR_MAX : CTR_WT;
      end
    end
  end

  // Tag/target carry no reset; a valid bit guards them. On a hit the tag rewrite is a no-op.
  always_ff @(posedge clk) begin
    if (resetn && ex_valid && ex_cf && ex_taken) begin
      tbl_tag[ex_idx]    <= ex_tag;
      tbl_target[ex_idx] <= ex_target;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_cf_count         <= '0;
      stat_mispredict_count <= '0;
    end else begin
      if (ex_valid && ex_cf && (stat_cf_count != 32'hFFFF_FFFF))
        stat_cf_count <= stat_cf_count + 32'd1;
      if (mispredict && (stat_mispredict_count != 32'hFFFF_FFFF))
        stat_mispredict_count <= stat_mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage core. It replaces the fixed predict-not-taken scheme, where every taken branch or jump resolved in EX flushes IF/ID and ID/EX.
- Looks up the IF-stage PC in a direct-mapped branch target buffer (BTB) with saturating counters and supplies the predicted next PC.
- Compares each EX-resolved outcome against the prediction carried down the pipe, raises a mispredict redirect, and trains the tables.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- CTR_BITS, 2, width of the per-entry saturating direction counter; minimum 1.
- ADDR_WIDTH, 32, PC / target width.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- if_pc  in  ADDR_WIDTH  PC currently in IF.
- pred_taken  out  1  lookup hit and counter MSB set.
- pred_next_pc  out  ADDR_WIDTH  entry target if pred_taken, else if_pc+4.
- ex_valid  in  1  non-bubble instruction in EX this cycle.
- ex_pc  in  ADDR_WIDTH  PC of the EX instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jump  in  1  EX instruction is JAL/JALR.
- ex_taken  in  1  resolved direction; must be 1 whenever ex_is_jump is 1.
- ex_target  in  ADDR_WIDTH  resolved target (ALU result).
- ex_pred_taken  in  1  pred_taken value piped alongside the instruction.
- ex_pred_next_pc  in  ADDR_WIDTH  pred_next_pc value piped alongside the instruction.
- mispredict  out  1  redirect the PC and flush IF/ID and ID/EX.
- redirect_pc  out  ADDR_WIDTH  correct next PC when mispredict is 1.

Behaviour:
- Indexing:
  - idx = pc[log2(ENTRIES)+1:2].
  - tag = pc[ADDR_WIDTH-1:log2(ENTRIES)+2].
  - Each entry holds valid, tag, target[ADDR_WIDTH-1:0] and ctr[CTR_BITS-1:0].
- Lookup is combinational (zero latency) from if_pc.
  - hit = valid[idx] and the tag matches.
  - pred_taken = hit and ctr[MSB].
  - PC+4 arithmetic wraps modulo 2^ADDR_WIDTH.
- Resolution, combinational, when ex_valid=1:
  - cf = ex_is_branch or ex_is_jump.
  - actual_next = ex_taken ? ex_target : ex_pc+4.
  - mispredict = (actual_next != ex_pred_next_pc) when cf=1; mispredict = ex_pred_taken when cf=0 (stale/aliased hit on a non-branch).
  - redirect_pc = actual_next when cf=1, ex_pc+4 when cf=0.
  - ex_valid=0: mispredict=0 and redirect_pc=0.
- Training is registered at posedge clk when ex_valid=1 and applies to the entry at ex_pc.
  - Hit, branch: ctr increments if taken, decrements if not; saturates at 2^CTR_BITS-1 and 0. If taken, target <= ex_target.
  - Hit, jump: ctr <= all ones; target <= ex_target.
  - Miss, taken: allocate (overwrite any occupant): valid=1, tag, target=ex_target. ctr = 10..0 (weakly taken) for a branch, all ones for a jump.
  - Miss, not taken: no write.
  - cf=0 with a hit: valid <= 0 (invalidate).
- Lookup and update to the same idx in the same cycle: lookup returns pre-update contents; no bypass.
- Reset (asynchronous, any time):
  - All valid <= 0.
  - ctr <= 01..1 (weakly not-taken); targets and tags don't-care.
  - pred_taken=0 and pred_next_pc=if_pc+4 immediately.
  - Any training update in flight is discarded.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds output ports stat_cf_count[31:0] and stat_mispredict_count[31:0].
  - Both reset to 0.
  - stat_cf_count increments on every cycle with ex_valid and cf.
  - stat_mispredict_count increments on every cycle with mispredict.
  - Both saturate at 32'hFFFFFFFF.
- When undefined, those ports and counters do not exist and the behaviour above is otherwise identical.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_next_pc=0x104; assert resetn=0 mid-run after training → pred_taken drops to 0 the same cycle.
- Branch at 0x40 resolved taken to 0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80; next cycle if_pc=0x40 → pred_taken=1, pred_next_pc=0x80.
- Same branch resolved not-taken twice → first gives mispredict=1, redirect_pc=0x44, ctr 10→01; second gives mispredict=0, ctr 01→00; ctr stays 00 on a further not-taken (saturation).
- JAL at 0x20 to 0x200, then JALR at 0x20 to 0x300 with ex_pred_next_pc=0x200 → mispredict=1, redirect_pc=0x300, entry target updated to 0x300.
- Aliasing (ENTRIES=16): 0x40 and 0x80 share idx 0. Train 0x40 taken to 0x100, then train 0x80 taken to 0x180 → lookup of 0x40 misses. A non-branch at 0x80 with ex_pred_taken=1 → mispredict=1, redirect_pc=0x84, entry invalidated.
- With BP_STATS_EN: 10 resolved branches, 3 mispredicted → stat_cf_count=10, stat_mispredict_count=3; bubbles (ex_valid=0) don't count.
